// File: rtl/alu_arbiter_pkg.sv
// Shared ALU op-code constants and the arbiter FSM state encoding.
package alu_arbiter_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_NOT = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0101;
   localparam logic [3:0] ALU_OR  = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way grant logic: round-robin on ties, or requester 0 always wins when FIXED_PRIO=1.
module rr_arb2 #(
   parameter int FIXED_PRIO = 0
) (
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   output logic grant0,
   output logic grant1
);

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (valid0 && valid1) begin
         // last_grant names the requester served previously; the other one wins the tie
         if ((FIXED_PRIO != 0) || last_grant) begin
            grant0 = 1'b1;
         end else begin
            grant1 = 1'b1;
         end
      end else begin
         grant0 = valid0;
         grant1 = valid1;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters; one op in flight at a time.
//   state | meaning
//   IDLE  | no op in flight, may grant a requester
//   EXEC  | issue register drives the ALU, result captured at cycle end
//   HOLD  | response presented until rsp_ready; may grant the next op on handshake
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int FIXED_PRIO = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_aluc,
   input  logic [4:0]  req0_shamt,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_aluc,
   input  logic [4:0]  req1_shamt,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic [3:0]  alu_aluc,
   output logic [4:0]  alu_shamt,
   output logic [31:0] alu_in1,
   output logic [31:0] alu_in2,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   output logic        rsp_valid,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic        rsp_zero,
   input  logic        rsp_ready
);

   state_t state;
   logic   last_grant;
   logic   issue_id;
   logic   grant0;
   logic   grant1;
   logic   accept;
   logic   take;

   rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .last_grant (last_grant),
      .grant0     (grant0),
      .grant1     (grant1)
   );

   // rst gating keeps ready low while reset is held, even though state already reads IDLE
   assign accept     = !rst && ((state == ST_IDLE) || ((state == ST_HOLD) && rsp_ready));
   assign req0_ready = accept && grant0;
   assign req1_ready = accept && grant1;
   assign take       = req0_ready || req1_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         last_grant <= 1'b1;
         issue_id   <= 1'b0;
         alu_aluc   <= 4'd0;
         alu_shamt  <= 5'd0;
         alu_in1    <= 32'd0;
         alu_in2    <= 32'd0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= 32'd0;
         rsp_zero   <= 1'b0;
      end else begin
         if (take) begin
            alu_aluc   <= req1_ready ? req1_aluc  : req0_aluc;
            alu_shamt  <= req1_ready ? req1_shamt : req0_shamt;
            alu_in1    <= req1_ready ? req1_a     : req0_a;
            alu_in2    <= req1_ready ? req1_b     : req0_b;
            issue_id   <= req1_ready;
            last_grant <= req1_ready;
         end
         case (state)
            ST_IDLE: begin
               if (take) state <= ST_EXEC;
            end
            ST_EXEC: begin
               rsp_result <= alu_result;
               rsp_zero   <= alu_zero;
               rsp_id     <= issue_id;
               rsp_valid  <= 1'b1;
               state      <= ST_HOLD;
            end
            ST_HOLD: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= take ? ST_EXEC : ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single ops plus hand-written arbitration,
// backpressure, reset-in-flight and fixed-priority sequences. The ALU is modelled here.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        r0_valid, r1_valid, r0_ready, r1_ready;
   logic [3:0]  r0_aluc, r1_aluc;
   logic [4:0]  r0_shamt, r1_shamt;
   logic [31:0] r0_a, r0_b, r1_a, r1_b;
   logic [3:0]  alu_aluc;
   logic [4:0]  alu_shamt;
   logic [31:0] alu_in1, alu_in2, alu_result;
   logic        alu_zero;
   logic        rsp_valid, rsp_id, rsp_zero, rsp_ready;
   logic [31:0] rsp_result;

   logic        f0_valid, f1_valid, f0_ready, f1_ready;
   logic [3:0]  f_aluc;
   logic [4:0]  f_shamt;
   logic [31:0] f_in1, f_in2, f_result;
   logic        f_zero, f_rsp_valid, f_rsp_id, f_rsp_zero;
   logic [31:0] f_rsp_result;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [4:0] sh,
                                             input logic [31:0] a, input logic [31:0] b);
      if (op[3]) return {31'b0, $signed(a) < $signed(b)};
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_NOT: return ~a;
         ALU_SLL: return a << sh;
         ALU_SRL: return a >> sh;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         default: return {31'b0, $signed(a) < $signed(b)};
      endcase
   endfunction

   assign alu_result = alu_model(alu_aluc, alu_shamt, alu_in1, alu_in2);
   assign alu_zero   = (alu_result == 32'd0);
   assign f_result   = alu_model(f_aluc, f_shamt, f_in1, f_in2);
   assign f_zero     = (f_result == 32'd0);

   alu_arbiter #(.FIXED_PRIO(0)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(r0_valid), .req0_ready(r0_ready), .req0_aluc(r0_aluc),
      .req0_shamt(r0_shamt), .req0_a(r0_a), .req0_b(r0_b),
      .req1_valid(r1_valid), .req1_ready(r1_ready), .req1_aluc(r1_aluc),
      .req1_shamt(r1_shamt), .req1_a(r1_a), .req1_b(r1_b),
      .alu_aluc(alu_aluc), .alu_shamt(alu_shamt), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
      .rsp_ready(rsp_ready)
   );

   alu_arbiter #(.FIXED_PRIO(1)) dut_fix (
      .clk(clk), .rst(rst),
      .req0_valid(f0_valid), .req0_ready(f0_ready), .req0_aluc(r0_aluc),
      .req0_shamt(r0_shamt), .req0_a(r0_a), .req0_b(r0_b),
      .req1_valid(f1_valid), .req1_ready(f1_ready), .req1_aluc(r1_aluc),
      .req1_shamt(r1_shamt), .req1_a(r1_a), .req1_b(r1_b),
      .alu_aluc(f_aluc), .alu_shamt(f_shamt), .alu_in1(f_in1), .alu_in2(f_in2),
      .alu_result(f_result), .alu_zero(f_zero),
      .rsp_valid(f_rsp_valid), .rsp_id(f_rsp_id), .rsp_result(f_rsp_result), .rsp_zero(f_rsp_zero),
      .rsp_ready(rsp_ready)
   );

   typedef struct {
      logic        id;
      logic [3:0]  aluc;
      logic [4:0]  shamt;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
      logic        exp_zero;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic id, input logic v, input logic [3:0] op, input logic [4:0] sh,
                        input logic [31:0] a, input logic [31:0] b);
      if (id) begin
         r1_valid = v; r1_aluc = op; r1_shamt = sh; r1_a = a; r1_b = b;
      end else begin
         r0_valid = v; r0_aluc = op; r0_shamt = sh; r0_a = a; r0_b = b;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[9];
      int   grants;
      vt[0] = '{1'b0, ALU_ADD, 5'd0, 32'd5,          32'd7,          32'd12,         1'b0};
      vt[1] = '{1'b1, ALU_SUB, 5'd0, 32'd9,          32'd9,          32'd0,          1'b1};
      vt[2] = '{1'b0, ALU_NOT, 5'd0, 32'h0000FFFF,   32'd0,          32'hFFFF0000,   1'b0};
      vt[3] = '{1'b1, ALU_SLL, 5'd8, 32'h12,         32'd0,          32'h1200,       1'b0};
      vt[4] = '{1'b0, ALU_SRL, 5'd4, 32'hF0,         32'd0,          32'hF,          1'b0};
      vt[5] = '{1'b1, ALU_AND, 5'd0, 32'hFF00FF00,   32'h0FF00FF0,   32'h0F000F00,   1'b0};
      vt[6] = '{1'b0, 4'b1010, 5'd0, 32'd3,          32'd8,          32'd1,          1'b0};
      vt[7] = '{1'b1, ALU_SLT, 5'd0, 32'hFFFFFFFF,   32'd1,          32'd1,          1'b0};
      vt[8] = '{1'b0, ALU_SUB, 5'd0, 32'd3,          32'd5,          32'hFFFFFFFE,   1'b0};

      f0_valid = 1'b0; f1_valid = 1'b0; rsp_ready = 1'b1;
      drive(1'b1, 1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
      drive(1'b0, 1'b1, ALU_ADD, 5'd0, 32'd1, 32'd2);
      rst = 1'b1;
      #2;
      check("rst_req0_ready", 32'(r0_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_result", rsp_result, 32'd0);
      check("rst_alu_in1", alu_in1, 32'd0);
      check("rst_alu_aluc", 32'(alu_aluc), 32'd0);
      r0_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tick();

      // single operations, one requester at a time, rsp_ready held high
      for (int i = 0; i < 9; i++) begin
         drive(vt[i].id, 1'b1, vt[i].aluc, vt[i].shamt, vt[i].a, vt[i].b);
         #1;
         check("vec_ready", 32'(vt[i].id ? r1_ready : r0_ready), 32'd1);
         check("vec_other_ready", 32'(vt[i].id ? r0_ready : r1_ready), 32'd0);
         tick();
         drive(vt[i].id, 1'b0, ~vt[i].aluc, ~vt[i].shamt, ~vt[i].a, ~vt[i].b);
         #1;
         check("vec_alu_aluc", 32'(alu_aluc), 32'(vt[i].aluc));
         check("vec_alu_shamt", 32'(alu_shamt), 32'(vt[i].shamt));
         check("vec_alu_in1", alu_in1, vt[i].a);
         check("vec_alu_in2", alu_in2, vt[i].b);
         check("vec_exec_rsp_valid", 32'(rsp_valid), 32'd0);
         tick();
         check("vec_rsp_valid", 32'(rsp_valid), 32'd1);
         check("vec_rsp_result", rsp_result, vt[i].exp_res);
         check("vec_rsp_zero", 32'(rsp_zero), 32'(vt[i].exp_zero));
         check("vec_rsp_id", 32'(rsp_id), 32'(vt[i].id));
         tick();
         check("vec_idle_rsp_valid", 32'(rsp_valid), 32'd0);
         check("vec_alu_held", alu_in1, vt[i].a);
      end

      // tie from reset: req0 first, then req1, third tie back to req0
      rst = 1'b1; #2; rst = 1'b0;
      drive(1'b0, 1'b1, ALU_SUB, 5'd0, 32'd9, 32'd9);
      drive(1'b1, 1'b1, ALU_OR, 5'd0, 32'hF0, 32'h0F);
      #1;
      check("tie1_req0_ready", 32'(r0_ready), 32'd1);
      check("tie1_req1_ready", 32'(r1_ready), 32'd0);
      tick();
      r0_valid = 1'b0;
      #1;
      check("tie1_exec_req1_ready", 32'(r1_ready), 32'd0);
      tick();
      check("tie1_rsp_result", rsp_result, 32'd0);
      check("tie1_rsp_zero", 32'(rsp_zero), 32'd1);
      check("tie1_rsp_id", 32'(rsp_id), 32'd0);
      check("tie2_req1_ready", 32'(r1_ready), 32'd1);
      tick();
      drive(1'b0, 1'b1, ALU_ADD, 5'd0, 32'd1, 32'd1);
      drive(1'b1, 1'b1, ALU_AND, 5'd0, 32'hFF, 32'h0F);
      #1;
      check("tie2_exec_req0_ready", 32'(r0_ready), 32'd0);
      tick();
      check("tie2_rsp_result", rsp_result, 32'hFF);
      check("tie2_rsp_id", 32'(rsp_id), 32'd1);
      check("tie3_req0_ready", 32'(r0_ready), 32'd1);
      check("tie3_req1_ready", 32'(r1_ready), 32'd0);
      tick();
      r0_valid = 1'b0;
      tick();
      check("tie3_rsp_result", rsp_result, 32'd2);
      check("tie3_rsp_id", 32'(rsp_id), 32'd0);
      check("tie4_req1_ready", 32'(r1_ready), 32'd1);
      tick();
      r1_valid = 1'b0;
      tick();
      check("tie4_rsp_result", rsp_result, 32'h0F);
      check("tie4_rsp_id", 32'(rsp_id), 32'd1);
      tick();
      check("tie_idle_rsp_valid", 32'(rsp_valid), 32'd0);

      // backpressure in HOLD, then req1 granted on the handshake cycle
      rsp_ready = 1'b0;
      drive(1'b0, 1'b1, ALU_ADD, 5'd0, 32'd2, 32'd3);
      #1;
      check("bp_req0_ready", 32'(r0_ready), 32'd1);
      tick();
      r0_valid = 1'b0;
      drive(1'b1, 1'b1, ALU_SUB, 5'd0, 32'd10, 32'd4);
      tick();
      for (int c = 0; c < 5; c++) begin
         check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp_rsp_result", rsp_result, 32'd5);
         check("bp_rsp_id", 32'(rsp_id), 32'd0);
         check("bp_req0_ready", 32'(r0_ready), 32'd0);
         check("bp_req1_ready", 32'(r1_ready), 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_release_req1_ready", 32'(r1_ready), 32'd1);
      tick();
      r1_valid = 1'b0;
      check("bp_exec_rsp_valid", 32'(rsp_valid), 32'd0);
      tick();
      check("bp_req1_rsp_result", rsp_result, 32'd6);
      check("bp_req1_rsp_id", 32'(rsp_id), 32'd1);
      tick();

      // reset while the SLL is in EXEC discards it
      drive(1'b0, 1'b1, ALU_SLL, 5'd4, 32'd1, 32'd0);
      #1;
      check("rx_req0_ready", 32'(r0_ready), 32'd1);
      tick();
      r0_valid = 1'b0;
      check("rx_exec_alu_aluc", 32'(alu_aluc), 32'(ALU_SLL));
      check("rx_exec_alu_in1", alu_in1, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("rx_alu_aluc", 32'(alu_aluc), 32'd0);
      check("rx_alu_shamt", 32'(alu_shamt), 32'd0);
      check("rx_alu_in1", alu_in1, 32'd0);
      check("rx_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rx_rsp_result", rsp_result, 32'd0);
      tick();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         check("rx_no_rsp_valid", 32'(rsp_valid), 32'd0);
         check("rx_no_rsp_result", rsp_result, 32'd0);
      end

      // fixed priority: req0 wins every tie, req1 never granted
      drive(1'b0, 1'b0, ALU_ADD, 5'd0, 32'd4, 32'd4);
      drive(1'b1, 1'b0, ALU_OR, 5'd0, 32'd1, 32'd2);
      f0_valid = 1'b1;
      f1_valid = 1'b1;
      grants = 0;
      #1;
      for (int c = 0; c < 10; c++) begin
         check("fix_req1_ready", 32'(f1_ready), 32'd0);
         if (f0_ready) grants++;
         if (f_rsp_valid) begin
            check("fix_rsp_id", 32'(f_rsp_id), 32'd0);
            check("fix_rsp_result", f_rsp_result, 32'd8);
         end
         tick();
      end
      check("fix_req0_grants", 32'(grants), 32'd5);
      f0_valid = 1'b0;
      f1_valid = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
